// File: rtl/turfio_cin_word_align.sv
// -----------------------------------------------------------------------------
// turfio_cin_word_align
//
// Word aligner for the CIN link. It takes the 4-bit-per-rxclk nibble stream
// from the ISERDES, searches the training pattern over 4 bit offsets and
// 8 nibble phases, verifies it, locks, and then delivers one aligned 32-bit
// command word every 8 rxclk cycles.
//
// Optional feature macro: TURFIO_CIN_ERRCNT_EN
//   When defined, adds a saturating mismatch counter (err_count_o, cleared by
//   err_clr_i). Mismatches seen while locked are then counted and no longer
//   drop lock.
//
// Ports:
//   rxclk_i      in   1   rxclk, sole clock
//   rst_i        in   1   synchronous active-high reset
//   data_i       in   4   ISERDES nibble, bit 0 earliest
//   train_i      in   1   high while the far end sends TRAIN_PATTERN
//   err_clr_i    in   1   (macro only) clear err_count_o, wins over increment
//   err_count_o  out  16  (macro only) saturating locked-mismatch count
//   word_o       out  32  aligned word, bit 0 earliest
//   word_valid_o out  1   one-cycle strobe qualifying word_o
//   locked_o     out  1   alignment locked
//   bitslip_o    out  2   selected bit offset
//   phase_o      out  3   selected capture nibble phase
// -----------------------------------------------------------------------------
module turfio_cin_word_align #(
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter int          LOCK_COUNT    = 4
) (
  input  logic        rxclk_i,
  input  logic        rst_i,
  input  logic [3:0]  data_i,
  input  logic        train_i,
`ifdef TURFIO_CIN_ERRCNT_EN
  input  logic        err_clr_i,
  output logic [15:0] err_count_o,
`endif
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        locked_o,
  output logic [1:0]  bitslip_o,
  output logic [2:0]  phase_o
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0] LOCK_CNT_C = LOCK_COUNT[3:0];

  logic [35:0] hist_q;
  logic [2:0]  phase_q;
  logic [1:0]  state_q, state_d;
  logic [1:0]  slip_q, slip_d;
  logic [2:0]  cap_q, cap_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        locked_q, locked_d;
`ifdef TURFIO_CIN_ERRCNT_EN
  logic [15:0] err_q, err_d;
`endif

  logic [3:0]  match_s;
  logic        any_match_s;
  logic [1:0]  first_k_s;
  logic [31:0] sel_cand_s;
  logic        sel_ok_s;
  logic        cap_hit_s;

  // Pattern comparison of the four candidate offsets in the history window.
  always_comb begin
    match_s = 4'd0;
    for (int k = 0; k < 4; k++) begin
      match_s[k] = (hist_q[k +: 32] == TRAIN_PATTERN);
    end
  end

  // Lowest matching offset wins when more than one candidate matches.
  always_comb begin
    any_match_s = |match_s;
    if (match_s[0]) begin
      first_k_s = 2'd0;
    end else if (match_s[1]) begin
      first_k_s = 2'd1;
    end else if (match_s[2]) begin
      first_k_s = 2'd2;
    end else begin
      first_k_s = 2'd3;
    end
  end

  assign sel_cand_s = hist_q[slip_q +: 32];
  assign sel_ok_s   = (sel_cand_s == TRAIN_PATTERN);
  assign cap_hit_s  = (phase_q == cap_q);

  // Alignment state machine and word capture next-state logic.
  always_comb begin
    state_d = state_q;
    slip_d  = slip_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
`ifdef TURFIO_CIN_ERRCNT_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_SEARCH: begin
        if (train_i && any_match_s) begin
          slip_d = first_k_s;
          cap_d  = phase_q;
          cnt_d  = 4'd1;
          if (LOCK_CNT_C == 4'd1) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_VERIFY;
          end
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_VERIFY: begin
        // Losing training at any time abandons the candidate alignment.
        if (!train_i) begin
          state_d = ST_SEARCH;
        end else if (cap_hit_s) begin
          if (sel_ok_s) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == LOCK_CNT_C) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_VERIFY;
            end
          end else begin
            state_d = ST_SEARCH;
          end
        end else begin
          state_d = ST_VERIFY;
        end
      end
      ST_LOCKED: begin
        if (cap_hit_s) begin
          // The word is emitted even when it turns out to break lock.
          word_d  = sel_cand_s;
          valid_d = 1'b1;
          if (train_i && !sel_ok_s) begin
`ifdef TURFIO_CIN_ERRCNT_EN
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end else begin
              err_d = err_q;
            end
`else
            state_d = ST_SEARCH;
`endif
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
`ifdef TURFIO_CIN_ERRCNT_EN
    if (err_clr_i) begin
      err_d = 16'd0;
    end else begin
      err_d = err_d;
    end
`endif
    locked_d = (state_d == ST_LOCKED);
  end

  // History shift, free-running phase counter and state registers.
  always_ff @(posedge rxclk_i) begin
    if (rst_i) begin
      hist_q   <= 36'd0;
      phase_q  <= 3'd0;
      state_q  <= ST_SEARCH;
      slip_q   <= 2'd0;
      cap_q    <= 3'd0;
      cnt_q    <= 4'd0;
      word_q   <= 32'd0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
`ifdef TURFIO_CIN_ERRCNT_EN
      err_q    <= 16'd0;
`endif
    end else begin
      hist_q   <= {data_i, hist_q[35:4]};
      phase_q  <= phase_q + 3'd1;
      state_q  <= state_d;
      slip_q   <= slip_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
`ifdef TURFIO_CIN_ERRCNT_EN
      err_q    <= err_d;
`endif
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign locked_o     = locked_q;
  assign bitslip_o    = slip_q;
  assign phase_o      = cap_q;
`ifdef TURFIO_CIN_ERRCNT_EN
  assign err_count_o  = err_q;
`endif

endmodule

// File: doc/turfio_cin_word_align.md
# turfio_cin_word_align

Word aligner directly downstream of the CIN ISERDES capture stage. Consumes the 4-bit-per-rxclk nibble stream, finds the 32-bit training pattern across all 4 bit offsets and 8 nibble phases, and locks. Once locked it emits one aligned 32-bit command word every 8 rxclk cycles to the SURF command decoder. Runs entirely in the rxclk domain.

## Interface
Parameters:
- TRAIN_PATTERN, 32'hA55A6996, training word; bit 0 is earliest in time.
- LOCK_COUNT, 4, consecutive verified pattern words required to lock (1..15).

Ports:
- rxclk_i  in  1  rxclk, sole clock.
- rst_i  in  1  reset; one clock, synchronous and active-high.
- data_i  in  4  ISERDES nibble; data_i[0] earliest bit.
- train_i  in  1  high while TURF transmits TRAIN_PATTERN continuously.
- word_o  out  32  aligned word; bit 0 earliest.
- word_valid_o  out  1  one-cycle strobe, word_o valid.
- locked_o  out  1  alignment locked.
- bitslip_o  out  2  selected bit offset.
- phase_o  out  3  selected capture nibble phase.

## Operation
- History: 36-bit shift register, each cycle hist <= {data_i, hist[35:4]}. Candidate word at offset k = hist[k +: 32], k = 0..3.
- Free-running 3-bit nibble phase counter, increments every cycle, wraps 7->0.
- States: SEARCH, VERIFY, LOCKED.
- SEARCH: if train_i, compare all 4 candidates with TRAIN_PATTERN every cycle. On any match, latch lowest matching k into bitslip, current phase into capture phase, set match count = 1, go VERIFY. No match or train_i low: stay.
- VERIFY: on each cycle where phase == capture phase: candidate[bitslip] == pattern -> count++, at count == LOCK_COUNT go LOCKED; mismatch -> SEARCH. train_i low on any cycle -> SEARCH. LOCK_COUNT == 1 locks immediately on the first SEARCH match (SEARCH -> LOCKED).
- LOCKED: locked_o = 1. On each capture-phase cycle, word_o <= candidate[bitslip], word_valid_o pulses next cycle. If train_i high and captured word != pattern -> SEARCH (lock lost; that word still emitted). train_i low: no checking.
- word_valid_o only asserted in LOCKED.
- Reset: state SEARCH, hist 0, phase 0, bitslip_o 0, phase_o 0, word_o 0, word_valid_o 0, locked_o 0, counters 0.
- rst_i mid-lock: all of the above next edge; any word pending is dropped.
- Entering SEARCH from VERIFY/LOCKED keeps bitslip_o/phase_o at last values until a new match.

## Timing
- Nibble sampled at edge N is in hist after N; comparison combinational on hist; state/capture registers update at edge N+1.
- word_o/word_valid_o registered: valid the cycle after the capture-phase cycle containing the last nibble of the word; total latency data_i -> word_o 2 edges for the final nibble.
- word_valid_o exactly 1 cycle high, period exactly 8 cycles while LOCKED.
- locked_o rises the same edge the state enters LOCKED; falls the edge it leaves.
- First word_valid_o at the next capture phase after lock (8 cycles later).

## Configuration
- TURFIO_CIN_ERRCNT_EN defined: adds ports err_count_o (out, 16, saturating count of pattern mismatches observed in LOCKED with train_i high) and err_clr_i (in, 1, synchronous clear; clear wins over simultaneous increment). err_count_o resets to 0. With this macro, a LOCKED mismatch increments the counter and does NOT drop lock; lock only drops on rst_i.
- Not defined: ports absent, mismatch in LOCKED with train_i -> SEARCH as above.

## Test plan
- Reset, train_i=1, pattern stream at bit offset 2 -> locked_o after 4 patterns, bitslip_o=2, word_o=32'hA55A6996 every 8 cycles.
- Sweep offsets 0..3 and all 8 phases -> lock every case, bitslip_o/phase_o match injected alignment.
- Lock, then corrupt one bit of one training word -> locked_o falls, SEARCH, relock after 4 more good words (macro on: err_count_o=1, lock held).
- In VERIFY after 2 matches, drop train_i -> back to SEARCH, locked_o stays 0.
- Locked, train_i=0, send 32'h12345678 -> word_o=32'h12345678, no lock loss.
- Assert rst_i while locked -> next cycle all outputs 0, state SEARCH.
